// File: rtl/taillight_pkg.sv
// taillight_pkg: mode encoding, lamp pattern constants and segment codes for taillight_monitor
package taillight_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        HAZARD = 3'd3,
        ERR    = 3'd4
    } mode_e;
    localparam logic [2:0] P0 = 3'b000;
    localparam logic [2:0] P1 = 3'b001;
    localparam logic [2:0] P2 = 3'b011;
    localparam logic [2:0] P3 = 3'b111;
    localparam logic [7:0] SEG_IDLE   = 8'hBF;
    localparam logic [7:0] SEG_LEFT   = 8'hC7;
    localparam logic [7:0] SEG_RIGHT  = 8'hAF;
    localparam logic [7:0] SEG_HAZARD = 8'h89;
    localparam logic [7:0] SEG_ERR    = 8'h86;
endpackage

// File: rtl/taillight_seg7.sv
// taillight_seg7: decodes a monitor mode into an active-low seven-segment glyph {dp,g..a}
module taillight_seg7
    import taillight_pkg::*;
(
    input  logic [2:0] mode_i,
    output logic [7:0] hex_o
);
    assign hex_o = mode_i == IDLE   ? SEG_IDLE   :
                   mode_i == LEFT   ? SEG_LEFT   :
                   mode_i == RIGHT  ? SEG_RIGHT  :
                   mode_i == HAZARD ? SEG_HAZARD : SEG_ERR;
endmodule

// File: rtl/taillight_monitor.sv
// taillight_monitor: checks Thunderbird tail-light lamp steps, counts flash cycles, shows mode on hex
// Optional build macro TAILMON_GLITCH_CHECK_EN flags lamp changes between ticks as errors.
module taillight_monitor
    import taillight_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             ADC_CLK_10,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             clr,
    input  logic [2:0]       lamp_l,
    input  logic [2:0]       lamp_r,
    output logic [2:0]       mode,
    output logic             err,
    output logic [CNT_W-1:0] cycles,
    output logic [7:0]       hex
);
    logic [5:0]       pair, prev_q, prev_d;
    mode_e            mode_q, mode_d, start_mode;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [7:0]       hex_q, hex_d;
    logic             start, step, back, glitch;

    assign pair  = {lamp_l, lamp_r};
    assign start = prev_q == {P0, P0} &&
                   (pair == {P0, P0} || pair == {P1, P0} || pair == {P0, P1} || pair == {P3, P3});
    assign step  = (prev_q == {P1, P0} && pair == {P2, P0}) || (prev_q == {P2, P0} && pair == {P3, P0}) ||
                   (prev_q == {P0, P1} && pair == {P0, P2}) || (prev_q == {P0, P2} && pair == {P0, P3});
    assign back  = pair == {P0, P0} &&
                   (prev_q == {P3, P0} || prev_q == {P0, P3} || prev_q == {P3, P3});
    assign start_mode = pair == {P1, P0} ? LEFT :
                        pair == {P0, P1} ? RIGHT :
                        pair == {P3, P3} ? HAZARD : IDLE;

`ifdef TAILMON_GLITCH_CHECK_EN
    logic [5:0] dly_q;
    logic       armed_q;
    // last cycle's lamps; armed_q masks the first edge after reset release
    always_ff @(posedge ADC_CLK_10 or negedge reset_n)
        if (!reset_n) begin
            dly_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            dly_q   <= pair;
            armed_q <= 1'b1;
        end
    assign glitch = armed_q && !tick && pair != dly_q;
`else
    assign glitch = 1'b0;
`endif

    // next state: clr dominates, ERR absorbs, otherwise validate the sampled step
    always_comb begin
        prev_d   = prev_q;
        mode_d   = mode_q;
        err_d    = err_q;
        cycles_d = cycles_q;
        if (clr) begin
            prev_d   = '0;
            mode_d   = IDLE;
            err_d    = 1'b0;
            cycles_d = '0;
        end else if (!err_q && (glitch || (tick && !(start || step || back)))) begin
            err_d  = 1'b1;
            mode_d = ERR;
        end else if (!err_q && tick) begin
            prev_d   = pair;
            mode_d   = start ? start_mode : mode_q;
            cycles_d = cycles_q + CNT_W'(back);
        end
    end

    taillight_seg7 u_seg7 (
        .mode_i (mode_d),
        .hex_o  (hex_d)
    );

    // state registers; hex follows next-state mode so it never lags
    always_ff @(posedge ADC_CLK_10 or negedge reset_n)
        if (!reset_n) begin
            prev_q   <= '0;
            mode_q   <= IDLE;
            err_q    <= 1'b0;
            cycles_q <= '0;
            hex_q    <= SEG_IDLE;
        end else begin
            prev_q   <= prev_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
            hex_q    <= hex_d;
        end

    assign mode   = mode_q;
    assign err    = err_q;
    assign cycles = cycles_q;
    assign hex    = hex_q;
endmodule

// File: doc/taillight_monitor.md
# taillight_monitor

Passive checker that sits beside the Thunderbird tail-light controller and reads its six lamp outputs back, the receiving end of the lamp pattern it drives. On each controller step strobe it decodes the left/right lamp pair into a mode (idle, left, right, hazard) and validates the step against the legal sequence. It counts completed flash cycles, latches a sticky error on any illegal pattern or transition, and drives one active-low seven-segment digit with the decoded mode.

## Interface
- CNT_W, 4, width of completed-cycle counter
- ADC_CLK_10  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle strobe; controller advanced its lamp state this cycle
- clr  in  1  synchronous clear of error/mode/counter, active-high
- lamp_l  in  3  left lamps {LC,LB,LA}
- lamp_r  in  3  right lamps {RC,RB,RA}
- mode  out  3  decoded mode (package encoding)
- err  out  1  sticky sequence error
- cycles  out  CNT_W  completed flash cycles, wrapping
- hex  out  8  {dp,g,f,e,d,c,b,a}, active-low, dp always 1

## Operation
- Registers: prev pair (l,r), mode, err, cycles, hex. Lamp inputs only sampled when tick=1.
- Legal successors of prev pair:
  - (000,000) -> (000,000) mode IDLE; (001,000) mode LEFT; (000,001) mode RIGHT; (111,111) mode HAZARD
  - (001,000)->(011,000)->(111,000)->(000,000); right side mirrored
  - (111,111)->(000,000)
- Return to (000,000) from (111,000), (000,111) or (111,111): cycles += 1 (wraps 2^CNT_W-1 -> 0), mode unchanged.
- (000,000) -> (000,000): mode becomes IDLE.
- Any other observed pair, or legal pair that is not a successor of prev: err=1, mode=ERR, prev unchanged. ERR is absorbing; further ticks are ignored until clr or reset.
- clr=1: mode IDLE, err 0, cycles 0, prev (000,000), hex 8'hBF. clr with tick in the same cycle: clr wins, sample discarded.
- Mode states: IDLE, LEFT, RIGHT, HAZARD, ERR; transitions only via the table above, clr or reset.
- Segment codes: IDLE '-' 8'hBF, LEFT 'L' 8'hC7, RIGHT 'r' 8'hAF, HAZARD 'H' 8'h89, ERR 'E' 8'h86.

## Timing
- Latency 1: tick sampled at edge N; mode, err, cycles and hex all valid after edge N, same edge. hex is registered from next-state mode, never lags mode.
- No output changes without tick, clr or reset.
- Reset values: mode IDLE (0), err 0, cycles 0, hex 8'hBF, prev (000,000).
- reset_n low mid-sequence clears all state immediately, no clock required; first tick after release is checked against (000,000).
- Back-to-back ticks on consecutive cycles are supported.

## Configuration
- TAILMON_GLITCH_CHECK_EN defined: a lamp input change (either side) on a cycle with tick=0 sets err and mode ERR at the next edge, same as an illegal pattern. Lamp inputs are held in a one-cycle delay register for comparison; the cycle of reset release is not checked.
- Undefined: lamps on non-tick cycles are ignored; no delay register.

## Structure
- taillight_pkg: mode encoding (IDLE=0, LEFT=1, RIGHT=2, HAZARD=3, ERR=4), lamp pattern constants P0=000, P1=001, P2=011, P3=111, segment constants above.
- One sub-module: taillight_seg7, combinational mode->segment decode feeding the hex register.

## Test plan
- Reset, no ticks -> mode 0, err 0, cycles 0, hex 8'hBF.
- Left sequence (001,000),(011,000),(111,000),(000,000) on ticks, repeated twice -> mode LEFT, hex 8'hC7, cycles 2, err 0.
- Hazard (111,111),(000,000) x3 then (000,000) -> cycles 3, final mode IDLE, hex 8'hBF.
- Right (000,001) then (000,111) skipping (000,011) -> err 1, mode ERR, hex 8'h86; further legal ticks leave err 1; clr -> err 0, cycles 0, hex 8'hBF.
- CNT_W=2: five left cycles -> cycles 1 (wrap); clr and tick together mid-sequence -> sample discarded, mode IDLE.
- TAILMON_GLITCH_CHECK_EN: lamp_l changes with tick=0 -> err 1 next edge; without the macro -> err stays 0.
